speed_ramp_controller: RTL

//  Consumes 4-bit speed commands from the SPI slave (spi_data_out/spi_data_valid_out),

---
 rtl/speed_ctrl_pkg.sv | 16 +
 rtl/pwm_generator.sv | 38 +++
 rtl/speed_ramp_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/speed_ctrl_pkg.sv
// Shared widths, limits and FSM encoding for the speed ramp controller.
// step_toward moves a speed one unit toward a target and holds once it gets there.
package speed_ctrl_pkg;
    localparam int                 SPEED_W   = 4;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 4'd15;
    localparam int                 PWM_TICKS = 15;

    typedef enum logic [1:0] {IDLE, RAMP, ESTOP} ramp_state_t;

    function automatic logic [SPEED_W-1:0] step_toward(input logic [SPEED_W-1:0] cur,
                                                       input logic [SPEED_W-1:0] tgt);
        if (cur < tgt)      return cur + 4'd1;
        else if (cur > tgt) return cur - 4'd1;
        else                return cur;
    endfunction
endpackage

// File: rtl/pwm_generator.sv
// PWM with a free-running prescaler and a 15-tick frame; pwm = tick_cnt < duty.
// The output compares live counters, so a new duty takes effect at once.
module pwm_generator
    import speed_ctrl_pkg::*;
#(
    parameter int PWM_PRESCALE = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] duty,
    output logic               pwm
);
    localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    logic [PW-1:0]      presc_q, presc_d;
    logic [SPEED_W-1:0] tick_q, tick_d;
    logic               tick;

    always_comb begin
        tick    = (presc_q == PW'(PWM_PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        tick_d  = tick_q;
        if (tick) tick_d = (tick_q == SPEED_W'(PWM_TICKS - 1)) ? '0 : tick_q + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // Tick count tops out at 14, so duty 15 is constant high and duty 0 constant low.
    assign pwm = (tick_q < duty);
endmodule

// File: rtl/speed_ramp_controller.sv
// Accepts speed commands, ramps the applied speed one unit per step period toward the
// target, and drives a PWM proportional to it; estop forces everything to zero.
module speed_ramp_controller
    import speed_ctrl_pkg::*;
#(
    parameter int RAMP_STEP_CYCLES = 50_000,
    parameter int PWM_PRESCALE     = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] spi_data_in,
    input  logic               spi_data_valid_in,
    input  logic               estop_in,
    output logic [SPEED_W-1:0] speed_target_out,
    output logic [SPEED_W-1:0] speed_current_out,
    output logic               pwm_out,
    output logic               busy_out,
    output logic               estop_active_out,
    output logic [7:0]         cmd_count_out
);
    localparam int TW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;

    ramp_state_t        state_q, state_d;
    logic [SPEED_W-1:0] target_q, target_d;
    logic [SPEED_W-1:0] current_q, current_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [7:0]         count_q, count_d;
    logic               terminal;

    assign terminal = (timer_q == TW'(RAMP_STEP_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        current_d = current_q;
        timer_d   = timer_q;
        count_d   = count_q;
        if (estop_in) begin
            state_d   = ESTOP;
            target_d  = '0;
            current_d = '0;
            timer_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (spi_data_valid_in) begin
                        target_d = spi_data_in;
                        count_d  = count_q + 8'd1;
                        timer_d  = '0;
                        if (spi_data_in != current_q) state_d = RAMP;
                    end
                end
                RAMP: begin
                    // A step always heads for the old target; a coincident command
                    // only retargets, and the timer keeps running across it.
                    if (terminal) begin
                        current_d = step_toward(current_q, target_q);
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                    if (spi_data_valid_in) begin
                        target_d = spi_data_in;
                        count_d  = count_q + 8'd1;
                    end
                    if (current_d == target_d) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end
                ESTOP:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            target_q  <= '0;
            current_q <= '0;
            timer_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            current_q <= current_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
        end
    end

    pwm_generator #(.PWM_PRESCALE(PWM_PRESCALE)) u_pwm (
        .clk   (clk),
        .reset (reset),
        .duty  (current_q),
        .pwm   (pwm_out)
    );

    assign speed_target_out  = target_q;
    assign speed_current_out = current_q;
    assign busy_out          = (state_q == RAMP);
    assign estop_active_out  = (state_q == ESTOP);
    assign cmd_count_out     = count_q;
endmodule
